// File: rtl/instr_encode_loader.sv
// Instruction-memory loader: packs {op, reg, imm} requests into 8-bit
// instruction words, range-checks immediates, and streams the words into
// the instruction memory write port. It stops when DEPTH words are written.
module instr_encode_loader #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [2:0]        in_reg,
  input  logic [7:0]        in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              full,
  output logic              err_range,
  output logic [ADDR_W:0]   wr_count
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] rg;
    logic [7:0] imm;
  } req_t;

  state_t state, state_nxt;
  req_t   req;
  logic   accept;
  logic   legal;
  logic [7:0] ic;
  logic   wr_pend;     // legal word accepted last cycle, due to be written now
  logic   wr;          // write actually issued this cycle
  logic   full_next;

  assign req = '{op: in_op, rg: in_reg, imm: in_imm};

  // Encode the request and decide whether its immediate fits the field
  always_comb begin
    ic    = {req.op, req.rg, req.imm[2:0]};
    legal = (req.imm[7:3] == 5'b00000);
    if (req.op == 2'b11) begin
      // jump: 4-bit signed offset, sign bit parked in ic[5], reg field ignored
      ic    = {2'b11, req.imm[7], 2'b00, req.imm[2:0]};
      legal = (req.imm[7:3] == 5'b00000) || (req.imm[7:3] == 5'b11111);
    end
  end

  // Count the pending write so in_ready drops before a DEPTH+1-th accept
  assign full_next = ((wr_count + CW'(wr_pend)) == DEPTH_C);
  assign accept    = in_valid && in_ready;
  // A start or reset cycle kills a pending write
  assign wr        = wr_pend && rst_n && !start;
  assign imem_we   = wr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start always (re)enters LOAD from any state
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        LOAD:    if (wr && (wr_count == LAST_C)) state_nxt = FULL;
        FULL:    state_nxt = FULL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: only LOAD accepts, and never in a start or reset cycle
  always_comb begin
    in_ready = 1'b0;
    full     = 1'b0;
    case (state)
      LOAD:    in_ready = rst_n && !start && !full_next;
      FULL:    full     = 1'b1;
      default: ;
    endcase
  end

  // Write pipeline, address/count bookkeeping and sticky range error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_pend    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      wr_count   <= '0;
      err_range  <= 1'b0;
    end else if (start) begin
      wr_pend    <= 1'b0;
      imem_addr  <= '0;
      wr_count   <= '0;
      err_range  <= 1'b0;
    end else begin
      wr_pend <= accept && legal;
      if (accept && legal)  imem_wdata <= ic;
      if (accept && !legal) err_range  <= 1'b1;
      if (wr) begin
        wr_count <= wr_count + CW'(1);
        // hold on the last word instead of wrapping back to 0
        if (wr_count != LAST_C) imem_addr <= imem_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a scoreboard queue holds the
// expected {addr, word} of each legal accept; a negedge monitor pops and
// compares every imem write.
module tb_instr_encode_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid, in_ready;
  logic [1:0]        in_op;
  logic [2:0]        in_reg;
  logic [7:0]        in_imm;
  logic              imem_we, full, err_range;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic [ADDR_W:0]   wr_count;

  int checks = 0;
  int errors = 0;

  // bench model
  logic [ADDR_W+7:0] sb[$];
  int   m_cnt  = 0;     // legal accepts this session (written + pending)
  logic m_load = 1'b0;
  logic m_err  = 1'b0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_reg(in_reg), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .full(full), .err_range(err_range), .wr_count(wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write monitor
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", imem_we, 1'b0);
      end else begin
        logic [ADDR_W+7:0] e;
        e = sb.pop_front();
        chk("write_addr_data", {imem_addr, imem_wdata}, e);
      end
    end
  end

  // One clock of stimulus; ok/ic give the expected legality and encoding.
  task automatic step(input logic v, input logic [1:0] op, input logic [2:0] rg,
                      input logic [7:0] imm, input logic st, input logic rn,
                      input logic ok, input logic [7:0] ic);
    logic exp_rdy;
    in_valid = v; in_op = op; in_reg = rg; in_imm = imm; start = st; rst_n = rn;
    exp_rdy = rn && m_load && !st && (m_cnt != DEPTH);
    @(negedge clk);
    chk("in_ready", in_ready, exp_rdy);
    if (v && exp_rdy) begin
      if (ok) begin
        sb.push_back({m_cnt[ADDR_W-1:0], ic});
        m_cnt++;
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (!rn) begin
      sb.delete(); m_cnt = 0; m_err = 1'b0; m_load = 1'b0;
    end else if (st) begin
      sb.delete(); m_cnt = 0; m_err = 1'b0; m_load = 1'b1;
    end
    in_valid = 1'b0; start = 1'b0; rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_start();
    step(1'b0, 2'b00, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_op = '0; in_reg = '0; in_imm = '0;

    // reset
    step(1'b0, 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_err", err_range, 1'b0);
    chk("rst_addr", imem_addr, '0);
    chk("rst_wdata", imem_wdata, 8'h00);
    chk("rst_count", wr_count, '0);

    // idle before start: no accepts
    step(1'b1, 2'b00, 3'd1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h09);

    // three basic encodings, back to back
    do_start();
    step(1'b1, 2'b00, 3'd2, 8'h05, 1'b0, 1'b1, 1'b1, 8'h15);
    step(1'b1, 2'b01, 3'd1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h4B);
    step(1'b1, 2'b10, 3'd3, 8'h06, 1'b0, 1'b1, 1'b1, 8'h9E);
    idle(2);
    chk("basic_count", wr_count, 5'd3);
    chk("basic_addr", imem_addr, 4'd3);
    chk("basic_err", err_range, 1'b0);
    chk("basic_drained", sb.size(), 0);

    // jump offsets: two legal, two out of range
    step(1'b1, 2'b11, 3'd7, 8'hFD, 1'b0, 1'b1, 1'b1, 8'hE5);
    step(1'b1, 2'b11, 3'd0, 8'h07, 1'b0, 1'b1, 1'b1, 8'hC7);
    step(1'b1, 2'b11, 3'd0, 8'hF7, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 2'b11, 3'd0, 8'h08, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(2);
    chk("jump_err", err_range, m_err);
    chk("jump_count", wr_count, 5'd5);
    chk("jump_addr", imem_addr, 4'd5);

    // rejected immediate, then the next legal one lands at the same address
    do_start();
    chk("start_clr_err", err_range, 1'b0);
    chk("start_clr_count", wr_count, '0);
    step(1'b1, 2'b00, 3'd0, 8'h09, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("reject_err", err_range, 1'b1);
    chk("reject_addr", imem_addr, 4'd0);
    step(1'b1, 2'b00, 3'd0, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01);
    idle(1);
    chk("after_reject_count", wr_count, 5'd1);
    chk("err_sticky", err_range, 1'b1);

    // fill: 20 requests offered, only DEPTH accepted
    do_start();
    for (int i = 0; i < 20; i++) begin
      logic [2:0] r;
      r = 3'(i);
      step(1'b1, 2'b00, r, {5'b0, r}, 1'b0, 1'b1, 1'b1, {2'b00, r, r});
    end
    idle(2);
    chk("fill_full", full, 1'b1);
    chk("fill_count", wr_count, 5'd16);
    chk("fill_addr", imem_addr, 4'd15);
    chk("fill_drained", sb.size(), 0);
    step(1'b1, 2'b01, 3'd1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h49);
    idle(1);
    chk("full_hold_count", wr_count, 5'd16);

    // start with in_valid while a write is pending
    do_start();
    chk("restart_full", full, 1'b0);
    step(1'b1, 2'b10, 3'd5, 8'h02, 1'b0, 1'b1, 1'b1, 8'hAA);
    step(1'b1, 2'b01, 3'd4, 8'h04, 1'b1, 1'b1, 1'b1, 8'h64);
    chk("start_kill_count", wr_count, '0);
    step(1'b1, 2'b00, 3'd6, 8'h07, 1'b0, 1'b1, 1'b1, 8'h37);
    idle(1);
    chk("start_kill_next", wr_count, 5'd1);

    // reset mid-stream with in_valid held high
    step(1'b1, 2'b00, 3'd1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h0A);
    step(1'b1, 2'b00, 3'd1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h0B);
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_addr", imem_addr, '0);
    chk("mid_rst_wdata", imem_wdata, 8'h00);
    chk("mid_rst_count", wr_count, '0);
    chk("mid_rst_err", err_range, 1'b0);
    step(1'b1, 2'b00, 3'd1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h0B);
    step(1'b1, 2'b00, 3'd1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h0B);
    chk("mid_rst_idle_count", wr_count, '0);
    do_start();
    step(1'b1, 2'b11, 3'd0, 8'hF8, 1'b0, 1'b1, 1'b1, 8'hE0);
    idle(2);
    chk("final_count", wr_count, 5'd1);
    chk("final_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
